ysyx_22050612_imem_resp: RTL and testbench
==========================================

# ysyx_22050612_imem_resp

Instruction-memory responder: the memory-side end of the core's fetch interface. The core presents a PC and this block returns the 32-bit instruction word. It holds a word-addressed instruction store, loaded through a write port, and answers one fetch at a time after a configurable latency. Requests and responses use valid/ready handshakes. Misaligned and out-of-range fetches return an error plus an `ebreak` word, so the core halts cleanly.

## Interface
Parameters:
- BASE, 64'h0000_0000_8000_0000, byte address of word 0
- DEPTH, 4096, number of 32-bit words (power of two)
- LATENCY, 2, cycles from request accept to resp_valid (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  block can accept a request
- req_addr  in  64  fetch PC (byte address)
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_inst  out  32  instruction word
- resp_err  out  1  misaligned or out-of-range fetch
- wr_en  in  1  store write enable (loader)
- wr_addr  in  64  write byte address, same mapping as req_addr
- wr_data  in  32  write data

One clock; reset is synchronous and active-high.

## Operation
- Word index: idx = (addr − BASE) >> 2.
- An address is in range when addr ≥ BASE and idx < DEPTH.
- Misaligned: addr[1:0] ≠ 0.
- Error condition: misaligned OR out of range.
- FSM states:
  - IDLE: req_ready=1. On accept (req_valid && req_ready), latch addr. Go to RESP if LATENCY==1, else WAIT with cnt=LATENCY−2.
  - WAIT: req_ready=0. If cnt==0, go to RESP; else decrement cnt.
  - RESP: resp_valid=1; resp_inst and resp_err hold stable until resp_ready.
    - resp_ready && !req_valid: go to IDLE.
    - resp_ready && req_valid: req_ready=1, so the new request is accepted in the same cycle. Latch it and branch as from IDLE.
- Response data is sampled from the store on the edge entering RESP.
  - Error response: resp_inst=32'h0010_0073 (ebreak), resp_err=1.
  - Normal response: resp_inst=mem[idx], resp_err=0.
- Writes:
  - wr_en writes mem[idx(wr_addr)] on the clock edge.
  - Out-of-range or misaligned writes are dropped.
  - Writes are accepted in every state.
- Write and read-sample of the same word on the same edge: the response returns the old data.
- Store contents are not affected by rst.

## Timing
- Reset values: state=IDLE, resp_valid=0, resp_inst=0, resp_err=0, cnt=0.
- req_ready=0 while rst is high.
- Latency: resp_valid rises exactly LATENCY cycles after the accept edge.
- Back-to-back throughput: one response per LATENCY cycles when resp_ready stays high.
- Backpressure: with resp_ready low, resp_valid, resp_inst and resp_err stay constant and no request is accepted.
- req_addr must be stable only in the accept cycle.
- rst mid-WAIT or mid-RESP: the in-flight request is dropped, outputs return to reset values on the next edge, and no response is emitted.

## Configuration
- YSYX_22050612_IMEM_SEQ_FAST_EN defined:
  - The block tracks last_addr and last_ok.
  - last_ok is set by every non-error accept and cleared by rst or any error accept.
  - An accept with last_ok && addr == last_addr+4 goes straight to RESP, giving 1-cycle latency regardless of LATENCY.
- Undefined: every fetch takes LATENCY cycles and no tracking logic is built.

## Test plan
- Reset, LATENCY=2: during rst, resp_valid=0 and req_ready=0. In the first cycle after rst drops, req_ready=1.
- Load mem[0]=32'h0000_0413 via wr_en. Fetch 0x8000_0000 with resp_ready=1 → resp_valid exactly 2 cycles after accept, resp_inst=32'h0000_0413, resp_err=0.
- Fetch 0x8000_0002, then 0x8000_0000+4*DEPTH → each returns resp_inst=32'h0010_0073 with resp_err=1.
- Hold resp_ready=0 for 5 cycles during RESP → outputs stable and req_ready=0. Raise resp_ready with req_valid=1 → the new request is accepted in the same cycle.
- Assert rst while in WAIT → no response ever appears. A fresh fetch afterwards returns correct data.
- With YSYX_22050612_IMEM_SEQ_FAST_EN, LATENCY=3, fetch 0x8000_0000 then 0x8000_0004:
  - first response arrives after 3 cycles, second after 1 cycle;
  - a following fetch to 0x8000_0010 takes 3 cycles.

Source files
------------

// File: rtl/ysyx_22050612_imem_resp.sv
// Instruction-memory responder: word store with loader write port, one fetch in flight, LATENCY-cycle responses.
// Optional YSYX_22050612_IMEM_SEQ_FAST_EN: a sequential (+4) fetch after a good one answers in 1 cycle.
module ysyx_22050612_imem_resp #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   addr_q;
  logic [31:0]   mem [DEPTH];

  function automatic logic addr_bad(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= 64'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return off[IW+1:2];
  endfunction

  logic          accept;
  logic          fast_hit;
  logic          direct;
  logic [63:0]   load_addr;
  logic          load_bad;
  logic [IW-1:0] load_idx;

  assign req_ready = !rst && ((state == IDLE) || ((state == RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

`ifdef YSYX_22050612_IMEM_SEQ_FAST_EN
  logic [63:0] last_addr;
  logic        last_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr <= '0;
      last_ok   <= 1'b0;
    end else if (accept) begin
      last_addr <= req_addr;
      last_ok   <= !addr_bad(req_addr);
    end
  end

  assign fast_hit = last_ok && (req_addr == last_addr + 64'd4);
`else
  assign fast_hit = 1'b0;
`endif

  assign direct = (LATENCY == 1) || fast_hit;

  // Only WAIT completes from the latched address; all other RESP entries come from a fresh accept.
  assign load_addr = (state == WAIT) ? addr_q : req_addr;
  assign load_bad  = addr_bad(load_addr);
  assign load_idx  = word_idx(load_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      resp_valid <= 1'b0;
      resp_inst  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_inst  <= load_bad ? EBREAK : mem[load_idx];
            resp_err   <= load_bad;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // An accept (from IDLE or a completing RESP) overrides the transitions above.
      if (accept) begin
        addr_q <= req_addr;
        if (direct) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_inst  <= load_bad ? EBREAK : mem[load_idx];
          resp_err   <= load_bad;
        end else begin
          state      <= WAIT;
          cnt        <= CNT_INIT;
          resp_valid <= 1'b0;
        end
      end
    end
  end

  // Store is not reset; bad writes are silently dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !addr_bad(wr_addr)) begin
      mem[word_idx(wr_addr)] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_imem_resp.sv
// Scoreboard bench for ysyx_22050612_imem_resp: driver pushes expected responses, monitor pops and compares.
module tb_ysyx_22050612_imem_resp;

  localparam int LAT   = 2;
  localparam int DEPTH = 4096;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  ysyx_22050612_imem_resp #(
    .BASE(64'h0000_0000_8000_0000), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples late in the low phase, after the driver has settled its inputs.
  logic        presented = 1'b0;
  logic [31:0] seen_inst;
  logic        seen_err;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        presented = 1'b0;
      end else if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
        end else begin
          if (!presented) begin
            presented = 1'b1;
            seen_inst = resp_inst;
            seen_err  = resp_err;
            chk("latency", 64'(cyc), 64'(q[0].due));
            chk("resp_inst", {32'd0, resp_inst}, {32'd0, q[0].inst});
            chk("resp_err", {63'd0, resp_err}, {63'd0, q[0].err});
          end else begin
            chk("hold_inst", {32'd0, resp_inst}, {32'd0, seen_inst});
            chk("hold_err", {63'd0, resp_err}, {63'd0, seen_err});
          end
          if (resp_ready) begin
            void'(q.pop_front());
            presented = 1'b0;
          end
        end
      end
    end
  end

  task automatic write_word(input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns one time unit after the accept edge.
  task automatic issue(input logic [63:0] a, input logic [31:0] inst, input logic err,
                       input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    #1;
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    e.inst = inst; e.err = err; e.due = cyc + lat;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [63:0] a, input logic [31:0] inst, input logic err);
    issue(a, inst, err, LAT, 1'b1);
    drain();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_inst", {32'd0, resp_inst}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);

    // Loader writes are legal during reset; the store ignores rst.
    write_word(64'h8000_0000, 32'h0000_0413);
    write_word(64'h8000_0004, 32'h00A0_0093);
    write_word(64'h8000_0008, 32'h1234_5678);
    write_word(64'h8000_0010, 32'h0000_0013);
    write_word(64'h8000_3FFC, 32'hDEAD_BEEF);
    write_word(64'h8000_0009, 32'hFFFF_FFFF);
    write_word(64'h8000_4000, 32'hFFFF_FFFF);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    fetch(64'h8000_0000, 32'h0000_0413, 1'b0);
    fetch(64'h8000_0002, EBREAK, 1'b1);
    fetch(64'h8000_4000, EBREAK, 1'b1);
    fetch(64'h7FFF_FFFC, EBREAK, 1'b1);
    fetch(64'h8000_3FFC, 32'hDEAD_BEEF, 1'b0);
    fetch(64'h8000_0008, 32'h1234_5678, 1'b0);

    // Overwrite a word on the same edge that samples it: old data expected.
    issue(64'h8000_0004, 32'h00A0_0093, 1'b0, LAT, 1'b1);
    wr_en = 1'b1; wr_addr = 64'h8000_0004; wr_data = 32'h1111_1111;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    drain();
    fetch(64'h8000_0004, 32'h1111_1111, 1'b0);

    // Backpressure, then a request accepted in the same cycle as the response handshake.
    resp_ready = 1'b0;
    issue(64'h8000_0000, 32'h0000_0413, 1'b0, LAT, 1'b1);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_resp_inst", {32'd0, resp_inst}, 64'h0000_0413);
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h8000_0008; resp_ready = 1'b1;
    #1;
    chk("same_cycle_accept", {63'd0, req_ready}, 64'd1);
    e.inst = 32'h1234_5678; e.err = 1'b0; e.due = cyc + LAT;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    // Reset while the request sits in WAIT: it must never be answered.
    issue(64'h8000_0000, 32'h0000_0413, 1'b0, LAT, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("midwait_rst_valid", {63'd0, resp_valid}, 64'd0);
      chk("midwait_rst_ready", {63'd0, req_ready}, 64'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("dropped_resp", {63'd0, resp_valid}, 64'd0);
    end
    fetch(64'h8000_0000, 32'h0000_0413, 1'b0);

`ifdef YSYX_22050612_IMEM_SEQ_FAST_EN
    issue(64'h8000_0004, 32'h1111_1111, 1'b0, 1, 1'b1);
    drain();
    fetch(64'h8000_0010, 32'h0000_0013, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
